// File: rtl/xor_mpm_request_frontend.sv
// Request front end for the pipelined XOR multi-ported BRAM: valid/ready request
// acceptance with hazard/conflict stalls, issue registers, and credit-gated response FIFOs.
module xor_mpm_request_frontend #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 1024,
    parameter int PORTS      = 32,
    parameter int RESP_DEPTH = 4,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid [PORTS-1:0],
    output logic             req_ready [PORTS-1:0],
    input  logic             req_we    [PORTS-1:0],
    input  logic [AW-1:0]    req_addr  [PORTS-1:0],
    input  logic [WIDTH-1:0] req_wdata [PORTS-1:0],
    output logic             rsp_valid [PORTS-1:0],
    input  logic             rsp_ready [PORTS-1:0],
    output logic [WIDTH-1:0] rsp_data  [PORTS-1:0],
    output logic [AW-1:0]    mem_addr  [PORTS-1:0],
    output logic [WIDTH-1:0] mem_d     [PORTS-1:0],
    output logic             mem_en    [PORTS-1:0],
    input  logic [WIDTH-1:0] mem_q     [PORTS-1:0]
);

    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam int KW = CW + 2;

    logic [AW-1:0]    r_mem_addr [PORTS];
    logic [WIDTH-1:0] r_mem_d    [PORTS];
    logic             r_mem_en   [PORTS];
    logic             r_issue_rd [PORTS];
    logic             r_tag1     [PORTS];
    logic             r_tag2     [PORTS];
    logic [WIDTH-1:0] r_fifo     [PORTS][RESP_DEPTH];
    logic [PW-1:0]    r_wptr     [PORTS];
    logic [PW-1:0]    r_rptr     [PORTS];
    logic [CW-1:0]    r_cnt      [PORTS];

    logic             w_hazard   [PORTS];
    logic             w_conflict [PORTS];
    logic             w_pop      [PORTS];
    logic             w_accept   [PORTS];
    logic [KW-1:0]    w_credit   [PORTS];

    always_comb begin
        for (int unsigned p = 0; p < PORTS; p++) begin
            w_hazard[p]   = 1'b0;
            w_conflict[p] = 1'b0;
            for (int unsigned q = 0; q < PORTS; q++) begin
                if (r_mem_en[q] && (r_mem_addr[q] == req_addr[p]))
                    w_hazard[p] = 1'b1;
            end
            // Same-cycle duplicate writes: the lowest-numbered valid writer wins.
            for (int unsigned q = 0; q < p; q++) begin
                if (req_valid[q] && req_we[q] && (req_addr[q] == req_addr[p]))
                    w_conflict[p] = 1'b1;
            end
            w_pop[p] = (r_cnt[p] != '0) && rsp_ready[p];
            // The entry leaving this cycle is already counted as freed so that
            // RESP_DEPTH = 4 sustains one read per cycle.
            w_credit[p] = KW'(r_cnt[p]) + KW'(r_issue_rd[p]) + KW'(r_tag1[p])
                        + KW'(r_tag2[p]) - KW'(w_pop[p]);
            if (rst || w_hazard[p])
                req_ready[p] = 1'b0;
            else if (req_we[p])
                req_ready[p] = !w_conflict[p];
            else
                req_ready[p] = (w_credit[p] < KW'(RESP_DEPTH));
            w_accept[p]  = req_valid[p] && req_ready[p];
            mem_addr[p]  = r_mem_addr[p];
            mem_d[p]     = r_mem_d[p];
            mem_en[p]    = r_mem_en[p];
            rsp_valid[p] = (r_cnt[p] != '0);
            rsp_data[p]  = r_fifo[p][r_rptr[p]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned p = 0; p < PORTS; p++) begin
                r_mem_addr[p] <= '0;
                r_mem_d[p]    <= '0;
                r_mem_en[p]   <= 1'b0;
                r_issue_rd[p] <= 1'b0;
                r_tag1[p]     <= 1'b0;
                r_tag2[p]     <= 1'b0;
                r_wptr[p]     <= '0;
                r_rptr[p]     <= '0;
                r_cnt[p]      <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < PORTS; p++) begin
                if (w_accept[p]) begin
                    r_mem_addr[p] <= req_addr[p];
                    r_mem_d[p]    <= req_wdata[p];
                    r_mem_en[p]   <= req_we[p];
                    r_issue_rd[p] <= !req_we[p];
                end else begin
                    r_mem_en[p]   <= 1'b0;
                    r_issue_rd[p] <= 1'b0;
                end
                r_tag1[p] <= r_issue_rd[p];
                r_tag2[p] <= r_tag1[p];

                if (r_tag2[p]) begin
                    assert (r_cnt[p] != CW'(RESP_DEPTH));
                    r_fifo[p][r_wptr[p]] <= mem_q[p];
                    r_wptr[p] <= (r_wptr[p] == PW'(RESP_DEPTH - 1)) ? '0 : r_wptr[p] + 1'b1;
                end
                if (w_pop[p])
                    r_rptr[p] <= (r_rptr[p] == PW'(RESP_DEPTH - 1)) ? '0 : r_rptr[p] + 1'b1;

                if (r_tag2[p] && !w_pop[p])
                    r_cnt[p] <= r_cnt[p] + 1'b1;
                else if (!r_tag2[p] && w_pop[p])
                    r_cnt[p] <= r_cnt[p] - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_xor_mpm_request_frontend.sv
// Directed bench for xor_mpm_request_frontend (4 ports) with a behavioural
// 2-cycle-latency memory model attached to the mem_* bundle.
module tb_xor_mpm_request_frontend;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid [3:0];
    logic        req_ready [3:0];
    logic        req_we    [3:0];
    logic [9:0]  req_addr  [3:0];
    logic [31:0] req_wdata [3:0];
    logic        rsp_valid [3:0];
    logic        rsp_ready [3:0];
    logic [31:0] rsp_data  [3:0];
    logic [9:0]  mem_addr  [3:0];
    logic [31:0] mem_d     [3:0];
    logic        mem_en    [3:0];
    logic [31:0] mem_q     [3:0];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    xor_mpm_request_frontend #(.WIDTH(32), .DEPTH(1024), .PORTS(4), .RESP_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mem_addr(mem_addr), .mem_d(mem_d), .mem_en(mem_en), .mem_q(mem_q)
    );

    // Memory model: read returns old data, q valid two cycles after issue.
    logic [31:0] mem [1024];
    logic [31:0] rd1 [3:0];
    logic [31:0] rd2 [3:0];
    bit          mem_init = 1'b0;

    function automatic logic [31:0] pat(input int a);
        return 32'hA500_0000 | 32'(a);
    endfunction

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
            mem_init <= 1'b1;
        end else begin
            for (int p = 0; p < 4; p++) begin
                rd1[p] <= mem[mem_addr[p]];
                rd2[p] <= rd1[p];
                if (mem_en[p]) mem[mem_addr[p]] <= mem_d[p];
            end
        end
    end

    always_comb for (int p = 0; p < 4; p++) mem_q[p] = rd2[p];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int p = 0; p < 4; p++) begin
            req_valid[p] = 1'b0;
            req_we[p]    = 1'b0;
            req_addr[p]  = '0;
            req_wdata[p] = '0;
            rsp_ready[p] = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            for (int p = 0; p < 4; p++) begin
                req_valid[p] = 1'($urandom);
                req_we[p]    = 1'($urandom);
                req_addr[p]  = 10'($urandom);
                req_wdata[p] = $urandom;
            end
            #1;
            for (int p = 0; p < 4; p++) begin
                checks++;
                if (req_ready[p] !== 1'b0) begin
                    errors++; $display("FAIL reset_ready p=%0d got=%b exp=0", p, req_ready[p]);
                end
                checks++;
                if (mem_en[p] !== 1'b0) begin
                    errors++; $display("FAIL reset_mem_en p=%0d got=%b exp=0", p, mem_en[p]);
                end
                checks++;
                if (rsp_valid[p] !== 1'b0) begin
                    errors++; $display("FAIL reset_rsp_valid p=%0d got=%b exp=0", p, rsp_valid[p]);
                end
            end
        end
        step();
        idle();
        rst = 1'b0;
        #1;
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (req_ready[p] !== 1'b1) begin
                errors++; $display("FAIL post_reset_ready p=%0d got=%b exp=1", p, req_ready[p]);
            end
            checks++;
            if (mem_addr[p] !== 10'h0) begin
                errors++; $display("FAIL post_reset_mem_addr p=%0d got=%h exp=0", p, mem_addr[p]);
            end
        end
    endtask

    task automatic test_write_then_read();
        int n;
        step();
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 10'h10; req_wdata[0] = 32'hDEADBEEF;
        #1;
        checks++;
        if (req_ready[0] !== 1'b1) begin
            errors++; $display("FAIL wr_accept got=%b exp=1", req_ready[0]);
        end
        step();
        req_valid[0] = 1'b0; req_we[0] = 1'b0;
        req_valid[2] = 1'b1; req_we[2] = 1'b0; req_addr[2] = 10'h10;
        #1;
        checks++;
        if (req_ready[2] !== 1'b0) begin
            errors++; $display("FAIL rd_hazard_stall got=%b exp=0", req_ready[2]);
        end
        checks++;
        if (mem_en[0] !== 1'b1 || mem_addr[0] !== 10'h10 || mem_d[0] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_issue got en=%b addr=%h d=%h exp en=1 addr=010 d=deadbeef",
                               mem_en[0], mem_addr[0], mem_d[0]);
        end
        step();
        #1;
        checks++;
        if (req_ready[2] !== 1'b1) begin
            errors++; $display("FAIL rd_after_stall got=%b exp=1", req_ready[2]);
        end
        step();
        req_valid[2] = 1'b0;
        n = 3;
        while (rsp_valid[2] !== 1'b1 && n < 20) begin
            step(); n++;
        end
        checks++;
        if (n != 6) begin
            errors++; $display("FAIL wr_rd_latency got_cycle=%0d exp_cycle=6", n);
        end
        checks++;
        if (rsp_data[2] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_rd_data got=%h exp=deadbeef", rsp_data[2]);
        end
        step();
        checks++;
        if (rsp_valid[2] !== 1'b0) begin
            errors++; $display("FAIL wr_rd_pop got=%b exp=0", rsp_valid[2]);
        end
    endtask

    task automatic test_write_conflict();
        int n;
        step();
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 10'h20; req_wdata[1] = 32'h1111;
        req_valid[3] = 1'b1; req_we[3] = 1'b1; req_addr[3] = 10'h20; req_wdata[3] = 32'h3333;
        #1;
        checks++;
        if (req_ready[1] !== 1'b1 || req_ready[3] !== 1'b0) begin
            errors++; $display("FAIL conflict_arb got r1=%b r3=%b exp r1=1 r3=0", req_ready[1], req_ready[3]);
        end
        step();
        req_valid[1] = 1'b0; req_we[1] = 1'b0;
        #1;
        checks++;
        if (req_ready[3] !== 1'b0) begin
            errors++; $display("FAIL conflict_hazard got=%b exp=0", req_ready[3]);
        end
        step();
        #1;
        checks++;
        if (req_ready[3] !== 1'b1) begin
            errors++; $display("FAIL conflict_late_accept got=%b exp=1", req_ready[3]);
        end
        step();
        req_valid[3] = 1'b0; req_we[3] = 1'b0;
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 10'h20;
        #1;
        checks++;
        if (req_ready[0] !== 1'b0) begin
            errors++; $display("FAIL conflict_rd_stall got=%b exp=0", req_ready[0]);
        end
        step();
        #1;
        checks++;
        if (req_ready[0] !== 1'b1) begin
            errors++; $display("FAIL conflict_rd_accept got=%b exp=1", req_ready[0]);
        end
        step();
        req_valid[0] = 1'b0;
        n = 1;
        while (rsp_valid[0] !== 1'b1 && n < 12) begin
            step(); n++;
        end
        checks++;
        if (n != 4) begin
            errors++; $display("FAIL conflict_rd_latency got=%0d exp=4", n);
        end
        checks++;
        if (rsp_data[0] !== 32'h3333) begin
            errors++; $display("FAIL conflict_rd_data got=%h exp=00003333", rsp_data[0]);
        end
        step();
    endtask

    task automatic test_streaming();
        step(); step();
        for (int c = 0; c < 22; c++) begin
            if (c < 16) begin
                req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 10'(c);
            end else begin
                req_valid[0] = 1'b0;
            end
            #1;
            if (c < 16) begin
                checks++;
                if (req_ready[0] !== 1'b1) begin
                    errors++; $display("FAIL stream_ready c=%0d got=%b exp=1", c, req_ready[0]);
                end
            end
            checks++;
            if (rsp_valid[0] !== ((c >= 4 && c < 20) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL stream_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid[0],
                                   (c >= 4 && c < 20));
            end
            if (c >= 4 && c < 20) begin
                checks++;
                if (rsp_data[0] !== pat(c - 4)) begin
                    errors++; $display("FAIL stream_data c=%0d got=%h exp=%h", c, rsp_data[0], pat(c - 4));
                end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int n;
        rsp_ready[1] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 10'(32'h30 + acc);
            #1;
            checks++;
            if (req_ready[1] !== ((c < 4) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL bp_ready c=%0d got=%b exp=%b", c, req_ready[1], (c < 4));
            end
            if (req_ready[1] === 1'b1) acc++;
            step();
        end
        req_valid[1] = 1'b0;
        rsp_ready[1] = 1'b1;
        #1;
        for (int j = 0; j < 4; j++) begin
            n = 0;
            while (rsp_valid[1] !== 1'b1 && n < 10) begin
                step(); n++;
            end
            checks++;
            if (rsp_valid[1] !== 1'b1 || rsp_data[1] !== pat(32'h30 + j)) begin
                errors++; $display("FAIL bp_drain j=%0d got valid=%b data=%h exp valid=1 data=%h",
                                   j, rsp_valid[1], rsp_data[1], pat(32'h30 + j));
            end
            step();
        end
        checks++;
        if (rsp_valid[1] !== 1'b0) begin
            errors++; $display("FAIL bp_empty got=%b exp=0", rsp_valid[1]);
        end
    endtask

    task automatic test_reset_midflight();
        int n;
        step();
        rsp_ready[2] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            req_valid[2] = 1'b1; req_we[2] = 1'b0; req_addr[2] = 10'(32'h40 + c);
            #1;
            checks++;
            if (req_ready[2] !== 1'b1) begin
                errors++; $display("FAIL mid_rd_accept c=%0d got=%b exp=1", c, req_ready[2]);
            end
            step();
        end
        req_valid[2] = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready[2] !== 1'b0) begin
            errors++; $display("FAIL mid_rst_ready got=%b exp=0", req_ready[2]);
        end
        step();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (rsp_valid[2] !== 1'b0) begin
                errors++; $display("FAIL mid_rst_rsp c=%0d got=%b exp=0", c, rsp_valid[2]);
            end
            step();
        end
        for (int c = 0; c < 7; c++) begin
            req_valid[2] = 1'b1; req_we[2] = 1'b0; req_addr[2] = 10'(32'h50 + ((c < 4) ? c : 4));
            #1;
            checks++;
            if (req_ready[2] !== ((c < 4) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL mid_credit c=%0d got=%b exp=%b", c, req_ready[2], (c < 4));
            end
            step();
        end
        req_valid[2] = 1'b0;
        rsp_ready[2] = 1'b1;
        #1;
        n = 0;
        while (rsp_valid[2] !== 1'b1 && n < 10) begin
            step(); n++;
        end
        checks++;
        if (rsp_data[2] !== pat(32'h50)) begin
            errors++; $display("FAIL mid_credit_data got=%h exp=%h", rsp_data[2], pat(32'h50));
        end
        for (int c = 0; c < 8; c++) step();
    endtask

    initial begin
        idle();
        test_reset();
        test_write_then_read();
        test_write_conflict();
        test_streaming();
        test_backpressure();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
